mux8_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 8:1 4-bit selection datapath among eight requesters.
- Each requester raises a request and presents a 4-bit word. The block grants one owner at a time, drives the 3-bit select address, and registers the selected word toward a single downstream sink.
- Ownership is bounded by a burst limit, so no requester can starve the others.
- Sits between the eight nibble sources and the shared sink.

---
 rtl/mux8_rr_arbiter_pkg.sv | 13 +
 rtl/mux8_rr_arbiter_pick.sv | 30 +++
 rtl/mux8_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared encodings and widths for the 8-way round-robin nibble arbiter.
package mux8_rr_arbiter_pkg;

    localparam int unsigned NREQ = 8;
    localparam int unsigned SELW = 3;
    localparam int unsigned DW   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mux8_rr_arbiter_pick.sv
// rr_pick8: combinational round-robin picker; searches req & ~mask upward from start, wrapping mod 8.
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [SELW-1:0] start,
    input  logic [NREQ-1:0] mask,
    output logic            found,
    output logic [SELW-1:0] idx
);

    logic [NREQ-1:0] eff;
    logic [SELW-1:0] cand;

    assign eff = req & ~mask;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = start + SELW'(i);
            if (!found && eff[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 nibble select path; bursts capped at MAX_BEATS per grant.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [DW-1:0]   in0,
    input  logic [DW-1:0]   in1,
    input  logic [DW-1:0]   in2,
    input  logic [DW-1:0]   in3,
    input  logic [DW-1:0]   in4,
    input  logic [DW-1:0]   in5,
    input  logic [DW-1:0]   in6,
    input  logic [DW-1:0]   in7,
    input  logic            sink_ready,
    output logic [NREQ-1:0] grant,
    output logic [SELW-1:0] addr,
    output logic [DW-1:0]   dout,
    output logic            dout_valid,
    output logic            busy
);

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [SELW-1:0] addr_q, addr_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic            dv_q, dv_d;

    logic [DW-1:0]   sel;
    logic [SELW-1:0] pick_start;
    logic [NREQ-1:0] pick_mask;
    logic            pick_found;
    logic [SELW-1:0] pick_idx;
    logic            owner_req;
    logic            fire;
    logic            last_beat;

    always_comb begin
        case (addr_q)
            3'd0:    sel = in0;
            3'd1:    sel = in1;
            3'd2:    sel = in2;
            3'd3:    sel = in3;
            3'd4:    sel = in4;
            3'd5:    sel = in5;
            3'd6:    sel = in6;
            default: sel = in7;
        endcase
    end

    // One picker serves both idle arbitration (from ptr, no mask) and
    // same-cycle handover (from owner+1 with the owner masked; grant_q is its one-hot).
    assign pick_start = (state_q == BUSY) ? addr_q + SELW'(1) : ptr_q;
    assign pick_mask  = (state_q == BUSY) ? grant_q : '0;

    rr_pick8 u_pick (
        .req   (req),
        .start (pick_start),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_req = req[addr_q];
    assign fire      = (state_q == BUSY) && owner_req && sink_ready;
    assign last_beat = (cnt_q == 4'(MAX_BEATS - 1));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    addr_d  = pick_idx;
                    grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    cnt_d   = '0;
                end
            end
            default: begin
                if (fire) begin
                    dout_d = sel;
                    dv_d   = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                end
                if (!owner_req || (fire && last_beat)) begin
                    ptr_d = addr_q + SELW'(1);
                    cnt_d = '0;
                    if (pick_found) begin
                        addr_d  = pick_idx;
                        grant_d = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            addr_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
        end
    end

    assign grant      = grant_q;
    assign addr       = addr_q;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign busy       = (state_q == BUSY);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with hand-computed expectations per cycle.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] req = '0;
    logic [3:0] in0 = 4'hA, in1 = 4'h1, in2 = 4'h2, in3 = 4'h3;
    logic [3:0] in4 = 4'h4, in5 = 4'h5, in6 = 4'h6, in7 = 4'h7;
    logic       sink_ready = 1'b0;
    logic [7:0] grant;
    logic [2:0] addr;
    logic [3:0] dout;
    logic       dout_valid;
    logic       busy;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned beats;

    mux8_rr_arbiter #(.MAX_BEATS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .in0        (in0),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .in4        (in4),
        .in5        (in5),
        .in6        (in6),
        .in7        (in7),
        .sink_ready (sink_ready),
        .grant      (grant),
        .addr       (addr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset lands mid-cycle so the asynchronous clear is observed before any edge.
    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_grant", 32'(grant), 32'h00);
        chk("rst_addr",  32'(addr), 32'h0);
        chk("rst_dout",  32'(dout), 32'h0);
        chk("rst_dv",    32'(dout_valid), 32'h0);
        chk("rst_busy",  32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("onehot", 32'($onehot0(grant)), 32'h1);
            if (!busy) chk("idle_grant", 32'(grant), 32'h0);
        end
    end

    initial begin
        // single requester: 4 beats, release, one idle cycle, re-grant
        req = 8'h01; sink_ready = 1'b1;
        do_reset();
        step();
        chk("t1_grant", 32'(grant), 32'h01);
        chk("t1_addr",  32'(addr), 32'h0);
        chk("t1_busy",  32'(busy), 32'h1);
        chk("t1_dv0",   32'(dout_valid), 32'h0);
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (dout_valid) beats++;
            chk("t1_dout", 32'(dout), 32'hA);
        end
        chk("t1_beats", beats, 4);
        chk("t1_rel_grant", 32'(grant), 32'h00);
        chk("t1_rel_busy",  32'(busy), 32'h0);
        step();
        chk("t1_regrant", 32'(grant), 32'h01);
        chk("t1_dv_idle", 32'(dout_valid), 32'h0);

        // 0 <-> 7 alternation with no idle bubble, wrap of ptr 7->0
        req = 8'h81;
        do_reset();
        step();
        chk("t2_grant0", 32'(grant), 32'h01);
        beats = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (dout_valid) beats++;
            chk("t2_busy", 32'(busy), 32'h1);
            if (k == 4)  begin chk("t2_g7", 32'(grant), 32'h80); chk("t2_a7", 32'(addr), 32'h7); end
            if (k == 5)  chk("t2_dout7", 32'(dout), 32'h7);
            if (k == 8)  begin chk("t2_g0", 32'(grant), 32'h01); chk("t2_a0", 32'(addr), 32'h0); end
            if (k == 9)  chk("t2_dout0", 32'(dout), 32'hA);
            if (k == 12) chk("t2_g7b", 32'(grant), 32'h80);
        end
        chk("t2_beats", beats, 12);

        // sink stall holds the grant and does not consume beats
        req = 8'h08; sink_ready = 1'b0;
        do_reset();
        step();
        chk("t3_grant", 32'(grant), 32'h08);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_hold_g",  32'(grant), 32'h08);
            chk("t3_hold_dv", 32'(dout_valid), 32'h0);
        end
        sink_ready = 1'b1;
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (dout_valid) beats++;
            chk("t3_dout", 32'(dout), 32'h3);
        end
        chk("t3_beats", beats, 4);
        chk("t3_rel", 32'(grant), 32'h00);

        // request dropped mid-burst hands over to requester 6 immediately
        req = 8'h44;
        do_reset();
        step();
        chk("t4_grant2", 32'(grant), 32'h04);
        beats = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            if (dout_valid) beats++;
            chk("t4_dout2", 32'(dout), 32'h2);
        end
        chk("t4_beats2", beats, 2);
        req = 8'h40;
        step();
        chk("t4_grant6", 32'(grant), 32'h40);
        chk("t4_addr6",  32'(addr), 32'h6);
        chk("t4_nodv",   32'(dout_valid), 32'h0);
        step();
        chk("t4_dv6",   32'(dout_valid), 32'h1);
        chk("t4_dout6", 32'(dout), 32'h6);

        // asynchronous reset mid-burst, then ptr restarts at 0
        req = 8'hFF;
        do_reset();
        step();
        chk("t5_grant0", 32'(grant), 32'h01);
        step();
        chk("t5_dv", 32'(dout_valid), 32'h1);
        do_reset();
        step();
        chk("t5_regrant0", 32'(grant), 32'h01);
        chk("t5_readdr0",  32'(addr), 32'h0);

        req = 8'h00;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
